xu_fctr_arb: RTL and testbench

- Scheduler in front of the XU per-thread flush delay counter.
- Several flush sources per thread each request a flush-hold window, and each source has its own programmable delay.
- The block merges these requests per thread and arbitrates the counter's single shared delay bus round-robin across threads, one load per cycle.
- Drives the counter's per-thread set pulses and delay value, and exports a per-thread hold indication to CPL.

---
 rtl/xu_fctr_pkg.sv | 19 +
 rtl/xu_fctr_arb_rr.sv | 30 +++
 rtl/xu_fctr_arb.sv | 149 ++++++++++++++
 tb/tb_xu_fctr_arb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/xu_fctr_pkg.sv
// Shared types and helpers for the XU flush-delay counter scheduler.
// Holds the per-thread state encoding, default delay width and a max-of-delays helper.
package xu_fctr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    RUN  = 2'b10
  } fctr_state_e;

  localparam int DFLT_DELAY_WIDTH = 4;
  localparam int DLY_MAXW         = 16;

  function automatic logic [DLY_MAXW-1:0] max_dly(input logic [DLY_MAXW-1:0] a,
                                                  input logic [DLY_MAXW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xu_fctr_arb_rr.sv
// Round-robin picker: one-hot grant to the first requester after ptr, wrapping; combinational.
// No backpressure; a grant is produced whenever any request bit is set.
module xu_fctr_arb_rr #(
  parameter int THREADS = 2,
  parameter int IW      = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic [THREADS-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [THREADS-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  int idx;

  // Scan farthest-first so the closest requester after ptr is written last and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = THREADS; i >= 1; i--) begin
      idx = (int'(ptr) + i) % THREADS;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/xu_fctr_arb.sv
// Per-thread flush-request merge + round-robin load scheduler for the XU flush delay counters.
// Request-to-load latency 2 cycles, one load per cycle; stats behind XU_FCTR_ARB_STAT_EN.
module xu_fctr_arb
  import xu_fctr_pkg::*;
#(
  parameter int THREADS     = 2,
  parameter int SRCS        = 3,
  parameter int DELAY_WIDTH = DFLT_DELAY_WIDTH
) (
  input  logic                        nclk,
  input  logic                        rst_b,
  input  logic [THREADS*SRCS-1:0]     req,
  input  logic [SRCS*DELAY_WIDTH-1:0] delay_cfg,
  input  logic [THREADS-1:0]          fctr_busy,
  output logic [THREADS-1:0]          fctr_set,
  output logic [DELAY_WIDTH-1:0]      fctr_delay,
  output logic [THREADS-1:0]          hold,
  output logic [THREADS-1:0]          pend
`ifdef XU_FCTR_ARB_STAT_EN
 ,output logic [THREADS*16-1:0]       stat_load,
  output logic [THREADS*16-1:0]       stat_wait
`endif
);

  localparam int IW = (THREADS > 1) ? $clog2(THREADS) : 1;

  fctr_state_e            state_q    [THREADS];
  fctr_state_e            state_d    [THREADS];
  logic [DELAY_WIDTH-1:0] pend_dly_q [THREADS];
  logic [DELAY_WIDTH-1:0] pend_dly_d [THREADS];
  logic [DELAY_WIDTH-1:0] req_dly    [THREADS];
  logic [THREADS-1:0]     req_any;
  logic [THREADS-1:0]     pend_q;
  logic [THREADS-1:0]     gnt;
  logic [IW-1:0]          gnt_idx;
  logic [IW-1:0]          rr_ptr;
  logic                   gnt_vld;

  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      req_dly[t] = '0;
      req_any[t] = 1'b0;
      for (int s = 0; s < SRCS; s++) begin
        if (req[t*SRCS+s]) begin
          req_any[t] = 1'b1;
          req_dly[t] = DELAY_WIDTH'(max_dly(DLY_MAXW'(req_dly[t]),
                                            DLY_MAXW'(delay_cfg[s*DELAY_WIDTH +: DELAY_WIDTH])));
        end
      end
    end
  end

  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      pend_q[t] = (state_q[t] == PEND);
    end
  end

  xu_fctr_arb_rr #(
    .THREADS (THREADS),
    .IW      (IW)
  ) u_rr (
    .req     (pend_q),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_vld = |gnt;

  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      state_d[t]    = state_q[t];
      pend_dly_d[t] = pend_dly_q[t];
      unique case (state_q[t])
        IDLE: begin
          if (req_any[t]) begin
            state_d[t]    = PEND;
            pend_dly_d[t] = req_dly[t];
          end
        end
        PEND: begin
          // A request landing on the grant cycle stays pending for a reload with only its own delay.
          if (gnt[t]) begin
            if (req_any[t]) pend_dly_d[t] = req_dly[t];
            else            state_d[t]    = RUN;
          end else if (req_any[t]) begin
            pend_dly_d[t] = DELAY_WIDTH'(max_dly(DLY_MAXW'(pend_dly_q[t]), DLY_MAXW'(req_dly[t])));
          end
        end
        RUN: begin
          if (req_any[t]) begin
            state_d[t]    = PEND;
            pend_dly_d[t] = req_dly[t];
          end else if (!fctr_busy[t] && !fctr_set[t]) begin
            state_d[t] = IDLE;
          end
        end
        default: state_d[t] = IDLE;
      endcase
    end
  end

  always_ff @(posedge nclk or negedge rst_b) begin
    if (!rst_b) begin
      for (int t = 0; t < THREADS; t++) begin
        state_q[t]    <= IDLE;
        pend_dly_q[t] <= '0;
      end
      fctr_set   <= '0;
      fctr_delay <= '0;
      rr_ptr     <= IW'(THREADS - 1);
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        state_q[t]    <= state_d[t];
        pend_dly_q[t] <= pend_dly_d[t];
      end
      fctr_set <= gnt;
      if (gnt_vld) begin
        fctr_delay <= pend_dly_q[gnt_idx];
        rr_ptr     <= gnt_idx;
      end
    end
  end

  assign pend = pend_q;
  assign hold = pend_q | fctr_set | fctr_busy;

`ifdef XU_FCTR_ARB_STAT_EN
  for (genvar t = 0; t < THREADS; t++) begin : g_stat
    logic [15:0] load_q;
    logic [15:0] wait_q;

    always_ff @(posedge nclk or negedge rst_b) begin
      if (!rst_b) begin
        load_q <= '0;
        wait_q <= '0;
      end else begin
        if (fctr_set[t] && (load_q != 16'hFFFF))          load_q <= load_q + 16'd1;
        if (pend_q[t] && !gnt[t] && (wait_q != 16'hFFFF)) wait_q <= wait_q + 16'd1;
      end
    end

    assign stat_load[t*16 +: 16] = load_q;
    assign stat_wait[t*16 +: 16] = wait_q;
  end
`endif

endmodule

// File: tb/tb_xu_fctr_arb.sv
// Directed bench for xu_fctr_arb: hand-computed set/delay/hold/pend expectations per scenario.
module tb_xu_fctr_arb;

  logic        nclk;
  logic        rst_b;
  logic [5:0]  req;
  logic [11:0] delay_cfg;
  logic [1:0]  fctr_busy;
  logic [1:0]  fctr_set;
  logic [3:0]  fctr_delay;
  logic [1:0]  hold;
  logic [1:0]  pend;
`ifdef XU_FCTR_ARB_STAT_EN
  logic [31:0] stat_load;
  logic [31:0] stat_wait;
`endif

  int n_cmp = 0;
  int n_err = 0;

  xu_fctr_arb #(
    .THREADS     (2),
    .SRCS        (3),
    .DELAY_WIDTH (4)
  ) dut (
    .nclk       (nclk),
    .rst_b      (rst_b),
    .req        (req),
    .delay_cfg  (delay_cfg),
    .fctr_busy  (fctr_busy),
    .fctr_set   (fctr_set),
    .fctr_delay (fctr_delay),
    .hold       (hold),
    .pend       (pend)
`ifdef XU_FCTR_ARB_STAT_EN
   ,.stat_load  (stat_load),
    .stat_wait  (stat_wait)
`endif
  );

  initial begin
    nclk = 1'b0;
    forever #5 nclk = ~nclk;
  end

  task automatic tick;
    @(posedge nclk);
    #1;
  endtask

  task automatic test_reset;
    rst_b = 1'b0; req = '0; delay_cfg = '0; fctr_busy = '0;
    #1;
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL rst_set: got %b want 00", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd0) begin n_err++; $display("FAIL rst_delay: got %0d want 0", fctr_delay); end
    n_cmp++; if (hold !== 2'b00) begin n_err++; $display("FAIL rst_hold: got %b want 00", hold); end
    n_cmp++; if (pend !== 2'b00) begin n_err++; $display("FAIL rst_pend: got %b want 00", pend); end
    @(posedge nclk); #3; rst_b = 1'b1;
    tick;
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL rst_rel_set: got %b want 00", fctr_set); end
  endtask

  task automatic test_contention;
    delay_cfg = {4'd7, 4'd4, 4'd0};
    req = 6'b100010;
    tick;
    n_cmp++; if (pend !== 2'b11) begin n_err++; $display("FAIL cont_pend1: got %b want 11", pend); end
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL cont_set0: got %b want 00", fctr_set); end
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL cont_set_t0: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd4) begin n_err++; $display("FAIL cont_dly_t0: got %0d want 4", fctr_delay); end
    n_cmp++; if (pend !== 2'b11) begin n_err++; $display("FAIL cont_pend2: got %b want 11", pend); end
    n_cmp++; if (hold !== 2'b11) begin n_err++; $display("FAIL cont_hold2: got %b want 11", hold); end
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b10) begin n_err++; $display("FAIL cont_set_t1: got %b want 10", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd7) begin n_err++; $display("FAIL cont_dly_t1: got %0d want 7", fctr_delay); end
    n_cmp++; if (pend !== 2'b01) begin n_err++; $display("FAIL cont_pend3: got %b want 01", pend); end
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL cont_set_t0b: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd4) begin n_err++; $display("FAIL cont_dly_t0b: got %0d want 4", fctr_delay); end
    tick;
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL cont_idle: got %b want 00", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd4) begin n_err++; $display("FAIL cont_dly_keep: got %0d want 4", fctr_delay); end
  endtask

  task automatic test_single;
    delay_cfg = {4'd9, 4'd5, 4'd3};
    req = 6'b000010;
    tick;
    n_cmp++; if (pend !== 2'b01) begin n_err++; $display("FAIL single_pend: got %b want 01", pend); end
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL single_hold1: got %b want 01", hold); end
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL single_early: got %b want 00", fctr_set); end
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL single_set: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd5) begin n_err++; $display("FAIL single_dly: got %0d want 5", fctr_delay); end
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL single_hold2: got %b want 01", hold); end
    fctr_busy = 2'b01;
    tick;
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL single_pulse: got %b want 00", fctr_set); end
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL single_hold3: got %b want 01", hold); end
    tick;
    fctr_busy = 2'b00;
    #1;
    n_cmp++; if (hold !== 2'b00) begin n_err++; $display("FAIL single_hold_end: got %b want 00", hold); end
    tick;
  endtask

  task automatic test_merge;
    delay_cfg = {4'd9, 4'd5, 4'd3};
    req = 6'b000101;
    tick;
    n_cmp++; if (pend !== 2'b01) begin n_err++; $display("FAIL merge_pend: got %b want 01", pend); end
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL merge_set: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd9) begin n_err++; $display("FAIL merge_dly: got %0d want 9", fctr_delay); end
    tick;
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL merge_single: got %b want 00", fctr_set); end
    // Thread1 wins this round, so thread0 sits in PEND while its src2 request merges in.
    req = 6'b010001;
    tick;
    n_cmp++; if (pend !== 2'b11) begin n_err++; $display("FAIL merge2_pend: got %b want 11", pend); end
    req = 6'b000100;
    tick;
    n_cmp++; if (fctr_set !== 2'b10) begin n_err++; $display("FAIL merge2_set_t1: got %b want 10", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd5) begin n_err++; $display("FAIL merge2_dly_t1: got %0d want 5", fctr_delay); end
    n_cmp++; if (pend !== 2'b01) begin n_err++; $display("FAIL merge2_pend2: got %b want 01", pend); end
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL merge2_set_t0: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd9) begin n_err++; $display("FAIL merge2_dly_t0: got %0d want 9", fctr_delay); end
    tick;
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL merge2_single: got %b want 00", fctr_set); end
    n_cmp++; if (pend !== 2'b00) begin n_err++; $display("FAIL merge2_pend3: got %b want 00", pend); end
  endtask

  task automatic test_delay0;
    delay_cfg = {4'd9, 4'd6, 4'd0};
    tick;
    req = 6'b000001;
    #1;
    n_cmp++; if (hold !== 2'b00) begin n_err++; $display("FAIL d0_hold_pre: got %b want 00", hold); end
    tick;
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL d0_hold_pend: got %b want 01", hold); end
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL d0_set: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd0) begin n_err++; $display("FAIL d0_dly: got %0d want 0", fctr_delay); end
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL d0_hold_set: got %b want 01", hold); end
    n_cmp++; if (pend !== 2'b00) begin n_err++; $display("FAIL d0_pend: got %b want 00", pend); end
    tick;
    n_cmp++; if (hold !== 2'b00) begin n_err++; $display("FAIL d0_hold_end: got %b want 00", hold); end
    tick;
    n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL d0_no_repeat: got %b want 00", fctr_set); end
  endtask

  task automatic test_reload;
    delay_cfg = {4'd9, 4'd6, 4'd2};
    req = 6'b000001;
    tick;
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL rl_set1: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd2) begin n_err++; $display("FAIL rl_dly1: got %0d want 2", fctr_delay); end
    fctr_busy = 2'b01;
    tick;
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL rl_hold_run: got %b want 01", hold); end
    req = 6'b000010;
    tick;
    n_cmp++; if (pend !== 2'b01) begin n_err++; $display("FAIL rl_pend: got %b want 01", pend); end
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL rl_hold_pend: got %b want 01", hold); end
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b01) begin n_err++; $display("FAIL rl_set2: got %b want 01", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd6) begin n_err++; $display("FAIL rl_dly2: got %0d want 6", fctr_delay); end
    tick;
    n_cmp++; if (hold !== 2'b01) begin n_err++; $display("FAIL rl_hold_after: got %b want 01", hold); end
    fctr_busy = 2'b00;
    tick;
    tick;
  endtask

  task automatic test_async_reset;
    delay_cfg = {4'd9, 4'd6, 4'd2};
    req = 6'b010000;
    tick;
    n_cmp++; if (pend !== 2'b10) begin n_err++; $display("FAIL ar_pend: got %b want 10", pend); end
    req = '0;
    #2; rst_b = 1'b0; #1;
    n_cmp++; if (pend !== 2'b00) begin n_err++; $display("FAIL ar_pend_clr: got %b want 00", pend); end
    n_cmp++; if (hold !== 2'b00) begin n_err++; $display("FAIL ar_hold_clr: got %b want 00", hold); end
    n_cmp++; if (fctr_delay !== 4'd0) begin n_err++; $display("FAIL ar_dly_clr: got %0d want 0", fctr_delay); end
    tick;
    #3; rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (fctr_set !== 2'b00) begin n_err++; $display("FAIL ar_no_pulse: got %b want 00", fctr_set); end
    end
    req = 6'b010000;
    tick;
    req = '0;
    tick;
    n_cmp++; if (fctr_set !== 2'b10) begin n_err++; $display("FAIL ar_new_set: got %b want 10", fctr_set); end
    n_cmp++; if (fctr_delay !== 4'd6) begin n_err++; $display("FAIL ar_new_dly: got %0d want 6", fctr_delay); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_merge();
    test_delay0();
    test_reload();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
